// File: rtl/counter_ctrl.sv
// counter_ctrl: sequences one load-and-count run of an external counter,
// watches the counter's feedback and reports completion, abort or mismatch.
module counter_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] preset,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt,
  output logic             load,
  output logic             en,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] tgt_q;

  logic             mismatch_c;
  logic             last_c;
  logic [WIDTH-1:0] tgt_m1_c;

  // Feedback check and terminal detect: stop one count short so the
  // increment already in flight lands exactly on the target.
  always_comb begin
    tgt_m1_c   = tgt_q - WIDTH'(1);
    mismatch_c = (cnt != exp_q);
    last_c     = (cnt == tgt_m1_c);
  end

  // Run sequencer with registered strobes; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      tgt_q   <= '0;
      data_in <= '0;
      load    <= 1'b0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
      err     <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            data_in <= preset;
            exp_q   <= preset;
            tgt_q   <= target;
            err     <= 1'b0;
            load    <= 1'b1;
            busy    <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          load <= 1'b0;
          if (stop) begin
            en      <= 1'b0;
            busy    <= 1'b0;
            abort   <= 1'b1;
            state_q <= IDLE;
          end else if (tgt_q != exp_q) begin
            en      <= 1'b1;
            state_q <= RUN;
          end else begin
            // Zero-length run: nothing to count.
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        RUN: begin
          exp_q <= exp_q + WIDTH'(1);
          if (stop) begin
            en      <= 1'b0;
            busy    <= 1'b0;
            abort   <= 1'b1;
            if (mismatch_c) begin
              err <= 1'b1;
            end
            state_q <= IDLE;
          end else if (mismatch_c) begin
            en      <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state_q <= IDLE;
          end else if (last_c) begin
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
